// File: rtl/trace_axis_packer.sv
// ---------------------------------------------------------------------------
// trace_axis_packer
//
// Packs 64-bit trace words into 512-bit AXI-Stream beats and frames the beats
// into packets of PKT_BEATS with tlast. A partially filled beat is flushed
// when the idle timer reaches cfg_timeout or when capture is disabled. Words
// arriving while capture is disabled are consumed, discarded and counted.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   cfg_enable               trace capture enable
//   cfg_timeout[TO_W]        idle cycles before a partial flush (0 = off)
//   s_trace_valid/ready/data 64-bit trace word input
//   m_axis_trace_*           512-bit packed output stream (tdata/tkeep/tlast)
//   drop_cnt[32]             saturating count of words discarded while disabled
// ---------------------------------------------------------------------------
module trace_axis_packer #(
    parameter int PKT_BEATS = 16,
    parameter int TO_W      = 16
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            cfg_enable,
    input  logic [TO_W-1:0] cfg_timeout,
    input  logic            s_trace_valid,
    output logic            s_trace_ready,
    input  logic [63:0]     s_trace_data,
    output logic            m_axis_trace_tvalid,
    input  logic            m_axis_trace_tready,
    output logic [511:0]    m_axis_trace_tdata,
    output logic [63:0]     m_axis_trace_tkeep,
    output logic            m_axis_trace_tlast,
    output logic [31:0]     drop_cnt
);

    localparam int                BEAT_W    = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_BEATS - 1);

    logic [7:0][63:0]  lane_q,     lane_d;
    logic [2:0]        pack_cnt_q, pack_cnt_d;
    logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              tvalid_q,   tvalid_d;
    logic [511:0]      tdata_q,    tdata_d;
    logic [63:0]       tkeep_q,    tkeep_d;
    logic              tlast_q,    tlast_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;

    logic out_free;
    logic timeout_hit;
    logic flush;
    logic s_ready;
    logic accept;
    logic drop;

    // Handshake qualification. A flush cycle blocks input so the lanes being
    // emitted cannot be overwritten in the same cycle.
    always_comb begin
        out_free    = !tvalid_q || m_axis_trace_tready;
        timeout_hit = (cfg_timeout != '0) && (idle_cnt_q >= cfg_timeout);
        flush       = (pack_cnt_q != 3'd0) && out_free && (timeout_hit || !cfg_enable);
        s_ready     = !flush && (!cfg_enable || (pack_cnt_q != 3'd7) || out_free);
        accept      = s_trace_valid && s_ready && cfg_enable;
        drop        = s_trace_valid && s_ready && !cfg_enable;
    end

    always_comb begin
        lane_d     = lane_q;
        pack_cnt_d = pack_cnt_q;
        idle_cnt_d = idle_cnt_q;
        beat_cnt_d = beat_cnt_q;
        tvalid_d   = tvalid_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tlast_d    = tlast_q;
        drop_cnt_d = drop_cnt_q;

        if (tvalid_q && m_axis_trace_tready) begin
            tvalid_d = 1'b0;
        end

        if (flush) begin
            // Lanes above pack_cnt may hold stale words from an earlier beat,
            // so they are masked to zero rather than copied.
            tdata_d = '0;
            tkeep_d = '0;
            for (int i = 0; i < 8; i++) begin
                if (3'(i) < pack_cnt_q) begin
                    tdata_d[64*i +: 64] = lane_q[i];
                    tkeep_d[8*i +: 8]   = 8'hFF;
                end
            end
            tlast_d    = 1'b1;
            tvalid_d   = 1'b1;
            pack_cnt_d = 3'd0;
            beat_cnt_d = '0;
            idle_cnt_d = '0;
        end else if (accept) begin
            idle_cnt_d = '0;
            if (pack_cnt_q == 3'd7) begin
                // Eighth word bypasses the pack register: no bubble.
                tdata_d    = {s_trace_data, lane_q[6:0]};
                tkeep_d    = '1;
                tlast_d    = (beat_cnt_q == LAST_BEAT);
                tvalid_d   = 1'b1;
                pack_cnt_d = 3'd0;
                beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + BEAT_W'(1);
            end else begin
                lane_d[pack_cnt_q] = s_trace_data;
                pack_cnt_d         = pack_cnt_q + 3'd1;
            end
        end else if (pack_cnt_q == 3'd0) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + TO_W'(1);
        end

        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lane_q     <= '0;
            pack_cnt_q <= 3'd0;
            idle_cnt_q <= '0;
            beat_cnt_q <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            tlast_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            lane_q     <= lane_d;
            pack_cnt_q <= pack_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tlast_q    <= tlast_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign s_trace_ready       = s_ready;
    assign m_axis_trace_tvalid = tvalid_q;
    assign m_axis_trace_tdata  = tdata_q;
    assign m_axis_trace_tkeep  = tkeep_q;
    assign m_axis_trace_tlast  = tlast_q;
    assign drop_cnt            = drop_cnt_q;

endmodule

// File: doc/trace_axis_packer.md
Name: trace_axis_packer

Overview:
- Sequences the 512-bit trace AXI-Stream leaving the role (m_axis_trace_*).
- Packs 64-bit trace words from the core-side trace source into 512-bit beats.
- Frames beats into packets of PKT_BEATS, with tlast.
- Flushes partial beats on idle timeout or when tracing is disabled; counts words dropped while disabled.

Parameters:
PKT_BEATS, 16, beats per full packet (>=1); tlast is asserted on the last beat.
TO_W, 16, width of the idle-timeout counter and cfg_timeout.

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
cfg_enable  in  1  trace capture enable
cfg_timeout  in  TO_W  idle cycles before partial flush; 0 = timeout disabled
s_trace_valid  in  1  input word valid
s_trace_ready  out  1  input word ready
s_trace_data  in  64  input trace word
m_axis_trace_tvalid  out  1  output beat valid
m_axis_trace_tready  in  1  downstream ready
m_axis_trace_tdata  out  512  packed beat
m_axis_trace_tkeep  out  64  byte enables
m_axis_trace_tlast  out  1  packet end
drop_cnt  out  32  saturating count of words discarded while disabled

Behaviour:
Reset values (all asynchronous on aresetn=0):
- tvalid=0, tdata=0, tkeep=0, tlast=0, drop_cnt=0.
- pack_cnt=0, beat_cnt=0, idle_cnt=0.
- Reset mid-packet discards all held data. No flush.

Storage and slot availability:
- Pack register: 8 lanes x 64 bits. Word k goes to bits [64k+63:64k]; lane 0 is filled first.
- pack_cnt ranges 0..7 and holds the number of filled lanes.
- Output register: a single slot. It holds tdata, tkeep, tlast and tvalid stable until tvalid && tready.
- out_free = !tvalid || tready (the slot is usable this cycle).

Accepting words:
- s_trace_ready = !cfg_enable || (pack_cnt<7) || out_free. It is forced to 0 in a flush cycle.
- Accept = s_trace_valid && s_trace_ready && cfg_enable.
- Accept with pack_cnt<7: lane[pack_cnt] <= data; pack_cnt++.
- Accept with pack_cnt==7: the 7 held lanes plus the incoming word go directly to the output register.
  - tkeep = all ones.
  - pack_cnt <= 0.
  - There is no bubble, so full throughput is 1 word/cycle.

Disabled input:
- cfg_enable=0 and s_trace_valid=1: the word is consumed (ready=1) and discarded.
- drop_cnt++, saturating at 0xFFFFFFFF.

Idle timer:
- idle_cnt resets to 0 on accept or when pack_cnt==0.
- Otherwise it increments, saturating at all ones.

Flush condition:
- pack_cnt>0 && out_free, and either:
  - cfg_timeout!=0 && idle_cnt>=cfg_timeout, or
  - cfg_enable==0.
- In a flush cycle: lanes 0..pack_cnt-1 go to the output register.
  - tkeep = 8 bytes set per valid lane, low lanes first.
  - Unused lanes are 0.
  - tlast = 1.
  - pack_cnt <= 0, beat_cnt <= 0, idle_cnt <= 0.
- If out_free=0, the flush waits and pack contents are held.

Packet framing:
- beat_cnt counts beats loaded into the output register.
- For a full beat: tlast = (beat_cnt==PKT_BEATS-1). beat_cnt then wraps to 0 if tlast, else increments.
- A partial flush always ends the packet.
- PKT_BEATS=1: every beat has tlast=1.

Other rules:
- Latency: from the accept of the 8th word to tvalid is 1 cycle.
- Simultaneous output handshake and new load in the same cycle is permitted (no bubble).
- cfg_timeout changes take effect immediately. A lowered value at or below the current idle_cnt flushes on the next eligible cycle.

Test Plan:
- Reset, enable=1, timeout=0, stream 128 words 0..127 with tready=1: 16 beats, word k at lane k%8, tkeep=all ones, tlast only on beat 15, zero idle cycles.
- 3 words 0xA,0xB,0xC then idle, timeout=10: flush beat appears 11 cycles after the last accept; tkeep=0x0000_0000_00FF_FFFF; lanes 3..7 zero; tlast=1.
- tready held 0 while 16 words are sent: the first beat stalls with tdata/tvalid stable; s_trace_ready drops after 15 words; release tready: both beats emitted in order, no loss.
- 5 words buffered, then enable->0 with 4 further words: partial flush (tkeep 40 bytes, tlast=1); the 4 words are consumed; drop_cnt=4.
- PKT_BEATS=16: 20 full beats, then a 2-word partial via timeout: tlast on beats 16 and 21; the partial beat starts a fresh packet count.
- Assert aresetn=0 with 6 words buffered and tvalid=1: all outputs 0 immediately; after release, no stale beat is emitted.
